// File: rtl/axi4_ram_pkg.sv
// Shared types and helpers for the AXI4 RAM slave.
package axi4_ram_pkg;

    // Controller phases. Only one burst is ever in flight.
    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StWresp,
        StRfetch,
        StRdata
    } state_e;

    // Number of low byte-address bits dropped to form a word index.
    function automatic int unsigned byte_shift(input int unsigned d_width);
        return $clog2(d_width / 8);
    endfunction

endpackage

// File: rtl/axi4_ram_mem.sv
// Single-port synchronous RAM with one cycle of read latency.
// Contents are never cleared; reset does not reach the array.
module axi4_ram_mem #(
    parameter int unsigned AWidth = 10,
    parameter int unsigned DWidth = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWidth-1:0] addr,
    input  logic [DWidth-1:0] wdata,
    output logic [DWidth-1:0] rdata
);

    logic [DWidth-1:0] mem [2**AWidth];

    // Registered read of the addressed word; write takes effect on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/axi4_ram_slave.sv
// AXI4 RAM slave: INCR bursts into a 2^MEM_AWIDTH-word RAM, one burst at a time.
// Optional feature: define AXI4_RAM_SLAVE_LAST_CHECK_EN to enable the sticky err
// flag (wlast mismatch inside a write burst, or wvalid outside a write burst).
module axi4_ram_slave
    import axi4_ram_pkg::*;
#(
    parameter int unsigned A_WIDTH    = 26,
    parameter int unsigned D_WIDTH    = 16,
    parameter int unsigned MEM_AWIDTH = 10
) (
    input  logic               aclk,
    input  logic               aresetn,
    // write address
    input  logic               awvalid,
    output logic               awready,
    input  logic [A_WIDTH-1:0] awaddr,
    input  logic [7:0]         awlen,
    // write data
    input  logic               wvalid,
    output logic               wready,
    input  logic               wlast,
    input  logic [D_WIDTH-1:0] wdata,
    // write response
    output logic               bvalid,
    input  logic               bready,
    // read address
    input  logic               arvalid,
    output logic               arready,
    input  logic [A_WIDTH-1:0] araddr,
    input  logic [7:0]         arlen,
    // read data
    output logic               rvalid,
    input  logic               rready,
    output logic               rlast,
    output logic [D_WIDTH-1:0] rdata,
    // sticky protocol error
    output logic               err
);

    localparam int unsigned Shift = byte_shift(D_WIDTH);

    state_e                  state_q, state_d;
    logic [MEM_AWIDTH-1:0]   idx_q, idx_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;

    logic                    mem_we;
    logic [MEM_AWIDTH-1:0]   mem_addr;
    logic [D_WIDTH-1:0]      mem_rdata;

    logic [MEM_AWIDTH-1:0]   aw_idx;
    logic [MEM_AWIDTH-1:0]   ar_idx;
    logic [MEM_AWIDTH-1:0]   idx_inc;
    logic                    last_beat;

    // Byte address to word index; the truncation gives the modulo wrap.
    assign aw_idx    = MEM_AWIDTH'(awaddr >> Shift);
    assign ar_idx    = MEM_AWIDTH'(araddr >> Shift);
    assign idx_inc   = idx_q + MEM_AWIDTH'(1);
    assign last_beat = (cnt_q == len_q);

    // State, burst index, length and beat counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, RAM control and handshake outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        mem_addr = idx_q;
        awready  = 1'b0;
        arready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rdata    = '0;
        unique case (state_q)
            StIdle: begin
                awready = 1'b1;
                // A pending write holds off the read so arvalid&arready never
                // forms a handshake that is then dropped.
                arready = !awvalid;
                if (awvalid) begin
                    idx_d   = aw_idx;
                    len_d   = awlen;
                    cnt_d   = '0;
                    state_d = StWdata;
                end else if (arvalid) begin
                    idx_d   = ar_idx;
                    len_d   = arlen;
                    cnt_d   = '0;
                    state_d = StRfetch;
                end
            end
            StWdata: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_inc;
                    cnt_d  = cnt_q + 8'd1;
                    // Burst length comes from awlen alone; wlast is not trusted.
                    if (last_beat) begin
                        state_d = StWresp;
                    end
                end
            end
            StWresp: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = StIdle;
                end
            end
            StRfetch: begin
                state_d = StRdata;
            end
            StRdata: begin
                rvalid = 1'b1;
                rlast  = last_beat;
                rdata  = mem_rdata;
                if (rready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        // Prefetch the next word so it lands without a bubble.
                        mem_addr = idx_inc;
                        idx_d    = idx_inc;
                        cnt_d    = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    axi4_ram_mem #(
        .AWidth (MEM_AWIDTH),
        .DWidth (D_WIDTH)
    ) u_mem (
        .clk   (aclk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

`ifdef AXI4_RAM_SLAVE_LAST_CHECK_EN
    logic err_q, err_d;

    // Raise err on a wlast that disagrees with the beat count, or on write
    // data offered while no write burst is open.
    always_comb begin
        err_d = err_q;
        if (wvalid) begin
            if (state_q == StWdata) begin
                if (wlast != last_beat) begin
                    err_d = 1'b1;
                end
            end else if (state_q != StWresp) begin
                err_d = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_wlast;
    assign unused_wlast = wlast;
    assign err          = 1'b0;
`endif

endmodule
